pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipe_controller
// Description : Pipelined ARM-style control unit. Decodes the instruction in
//               D, carries its controls through the E/M/W registers, resolves
//               the condition field against the architectural NZCV register
//               in E and kills the instruction's side effects when it fails.
// Ports       : clk          rising-edge clock
//               reset        asynchronous active-low reset
//               Op/Funct/Rd/Cond   decode-stage instruction fields
//               ALUFlags     NZCV from the execute-stage ALU
//               StallE/FlushE      hazard-unit controls (flush wins)
//               RegSrcD/ImmSrcD    decode-stage operand selects
//               ALUControlE/ALUSrcE/MemToRegE/BranchTakenE  execute stage
//               RegWriteM/MemWriteM/MemToRegM/PCSrcM        memory stage
//               RegWriteW/MemToRegW/PCSrcW                  writeback stage
//               FlagsQ       architectural NZCV register
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_controller #(
    parameter int ALUW  = 4,
    parameter int CONDW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic [CONDW-1:0] Cond,
    input  logic [3:0]       ALUFlags,
    input  logic             StallE,
    input  logic             FlushE,
    output logic [1:0]       RegSrcD,
    output logic [1:0]       ImmSrcD,
    output logic [ALUW-1:0]  ALUControlE,
    output logic             ALUSrcE,
    output logic             MemToRegE,
    output logic             BranchTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemToRegM,
    output logic             PCSrcM,
    output logic             RegWriteW,
    output logic             MemToRegW,
    output logic             PCSrcW,
    output logic [3:0]       FlagsQ
);

    // Only a 4-bit condition field and ALU codes of at least 4 bits make sense.
    generate
        if (CONDW != 4) begin : g_condwGuard
            $error("pipe_controller: CONDW must be 4");
        end
        if (ALUW < 4) begin : g_aluwGuard
            $error("pipe_controller: ALUW must be at least 4");
        end
    endgenerate

    // Data-processing command codes; the ALU control code equals the command.
    localparam logic [3:0] c_cmdAnd = 4'b0000;
    localparam logic [3:0] c_cmdSub = 4'b0010;
    localparam logic [3:0] c_cmdAdd = 4'b0100;
    localparam logic [3:0] c_cmdTst = 4'b1000;
    localparam logic [3:0] c_cmdCmp = 4'b1010;

    // ------------------------------------------------------------------ decode
    logic [3:0] w_cmd;
    logic       w_regWriteD, w_memWriteD, w_memToRegD, w_branchD, w_aluSrcD;
    logic       w_pcSrcD;
    logic [3:0] w_aluCtrlD;
    logic [1:0] w_flagWriteD, w_regSrcD, w_immSrcD;

    assign w_cmd = Funct[4:1];

    always_comb begin
        w_regWriteD  = 1'b0;
        w_memWriteD  = 1'b0;
        w_memToRegD  = 1'b0;
        w_branchD    = 1'b0;
        w_aluSrcD    = 1'b0;
        w_aluCtrlD   = 4'b0000;
        w_flagWriteD = 2'b00;
        w_regSrcD    = 2'b00;
        w_immSrcD    = 2'b00;
        case (Op)
            2'b00: begin
                w_aluSrcD   = Funct[5];
                w_aluCtrlD  = w_cmd;
                w_regWriteD = 1'b1;
                // ADD/SUB update all of NZCV; logical ops only N and Z.
                if (Funct[0])
                    w_flagWriteD = (w_cmd == c_cmdAdd || w_cmd == c_cmdSub) ? 2'b11 : 2'b10;
                // Compare/test run through the ALU but never write a register.
                if (w_cmd == c_cmdCmp) begin
                    w_aluCtrlD   = c_cmdSub;
                    w_regWriteD  = 1'b0;
                    w_flagWriteD = 2'b11;
                end else if (w_cmd == c_cmdTst) begin
                    w_aluCtrlD   = c_cmdAnd;
                    w_regWriteD  = 1'b0;
                    w_flagWriteD = 2'b10;
                end
            end
            2'b01: begin
                w_aluSrcD   = ~Funct[5];
                w_aluCtrlD  = Funct[3] ? c_cmdAdd : c_cmdSub;
                w_regWriteD = Funct[0];
                w_memToRegD = Funct[0];
                w_memWriteD = ~Funct[0];
                w_regSrcD   = 2'b10;
                w_immSrcD   = 2'b01;
            end
            2'b10: begin
                w_branchD   = 1'b1;
                w_aluSrcD   = 1'b1;
                w_aluCtrlD  = c_cmdAdd;
                w_immSrcD   = 2'b10;
                w_regSrcD   = 2'b01;
                w_regWriteD = Funct[4];
            end
            default: ;  // Op=11: bubble
        endcase
    end

    // Writing R15 redirects the PC; a branch-with-link writes R14, never PC.
    assign w_pcSrcD = w_regWriteD & (Rd == 4'hF) & (Op != 2'b10);

    assign RegSrcD = w_regSrcD;
    assign ImmSrcD = w_immSrcD;

    // ----------------------------------------------------------------- E stage
    logic             r_regWriteE, r_memWriteE, r_memToRegE, r_branchE;
    logic             r_aluSrcE, r_pcSrcE;
    logic [ALUW-1:0]  r_aluCtrlE;
    logic [1:0]       r_flagWriteE;
    logic [CONDW-1:0] r_condE;
    logic [3:0]       r_flags;
    logic             w_condEx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || FlushE) begin
            r_regWriteE  <= 1'b0;
            r_memWriteE  <= 1'b0;
            r_memToRegE  <= 1'b0;
            r_branchE    <= 1'b0;
            r_aluSrcE    <= 1'b0;
            r_pcSrcE     <= 1'b0;
            r_aluCtrlE   <= '0;
            r_flagWriteE <= 2'b00;
            r_condE      <= '0;
        end else if (!StallE) begin
            r_regWriteE  <= w_regWriteD;
            r_memWriteE  <= w_memWriteD;
            r_memToRegE  <= w_memToRegD;
            r_branchE    <= w_branchD;
            r_aluSrcE    <= w_aluSrcD;
            r_pcSrcE     <= w_pcSrcD;
            r_aluCtrlE   <= ALUW'(w_aluCtrlD);
            r_flagWriteE <= w_flagWriteD;
            r_condE      <= Cond;
        end
    end

    // Condition check uses the flag register as it stood at the start of the
    // cycle; a flag-setting instruction ahead in E does not forward.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = r_flags;
        w_condEx = 1'b0;
        case (r_condE[3:0])
            4'b0000: w_condEx = z;
            4'b0001: w_condEx = ~z;
            4'b0010: w_condEx = c;
            4'b0011: w_condEx = ~c;
            4'b0100: w_condEx = n;
            4'b0101: w_condEx = ~n;
            4'b0110: w_condEx = v;
            4'b0111: w_condEx = ~v;
            4'b1000: w_condEx = c & ~z;
            4'b1001: w_condEx = ~c | z;
            4'b1010: w_condEx = (n == v);
            4'b1011: w_condEx = (n != v);
            4'b1100: w_condEx = ~z & (n == v);
            4'b1101: w_condEx = z | (n != v);
            4'b1110: w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    assign ALUControlE  = r_aluCtrlE;
    assign ALUSrcE      = r_aluSrcE;
    assign MemToRegE    = r_memToRegE;
    assign BranchTakenE = r_branchE & w_condEx;

    // An instruction that is stalled or flushed this cycle must not commit.
    logic w_advanceE;
    assign w_advanceE = ~StallE & ~FlushE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (r_flagWriteE[1] & w_condEx & w_advanceE)
                r_flags[3:2] <= ALUFlags[3:2];
            if (r_flagWriteE[0] & w_condEx & w_advanceE)
                r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign FlagsQ = r_flags;

    // ------------------------------------------------------------- M/W stages
    logic r_regWriteM, r_memWriteM, r_memToRegM, r_pcSrcM;
    logic r_regWriteW, r_memToRegW, r_pcSrcW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || !w_advanceE) begin
            r_regWriteM <= 1'b0;
            r_memWriteM <= 1'b0;
            r_memToRegM <= 1'b0;
            r_pcSrcM    <= 1'b0;
        end else begin
            r_regWriteM <= r_regWriteE & w_condEx;
            r_memWriteM <= r_memWriteE & w_condEx;
            r_memToRegM <= r_memToRegE;
            r_pcSrcM    <= r_pcSrcE & w_condEx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regWriteW <= 1'b0;
            r_memToRegW <= 1'b0;
            r_pcSrcW    <= 1'b0;
        end else begin
            r_regWriteW <= r_regWriteM;
            r_memToRegW <= r_memToRegM;
            r_pcSrcW    <= r_pcSrcM;
        end
    end

    assign RegWriteM = r_regWriteM;
    assign MemWriteM = r_memWriteM;
    assign MemToRegM = r_memToRegM;
    assign PCSrcM    = r_pcSrcM;
    assign RegWriteW = r_regWriteW;
    assign MemToRegW = r_memToRegW;
    assign PCSrcW    = r_pcSrcW;

endmodule
`default_nettype wire

// File: tb/tb_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_controller
// Description : Directed bench for pipe_controller. Stimulus pushes expected
//               (cycle, signal, value) records into a scoreboard; a monitor
//               on the falling edge pops and compares the records due that
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd, Cond, ALUFlags;
    logic       StallE, FlushE;
    logic [1:0] RegSrcD, ImmSrcD;
    logic [3:0] ALUControlE;
    logic       ALUSrcE, MemToRegE, BranchTakenE;
    logic       RegWriteM, MemWriteM, MemToRegM, PCSrcM;
    logic       RegWriteW, MemToRegW, PCSrcW;
    logic [3:0] FlagsQ;

    pipe_controller #(.ALUW(4), .CONDW(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
        .ALUFlags(ALUFlags), .StallE(StallE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
        .PCSrcM(PCSrcM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .PCSrcW(PCSrcW), .FlagsQ(FlagsQ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_RWM = 0,  S_MWM = 1,  S_MRM = 2,  S_PCM = 3;
    localparam int S_RWW = 4,  S_MRW = 5,  S_PCW = 6,  S_FLG = 7;
    localparam int S_BTE = 8,  S_ALE = 9,  S_ASE = 10, S_MRE = 11;
    localparam int S_RSD = 12, S_ISD = 13;
    string names[14] = '{"RegWriteM", "MemWriteM", "MemToRegM", "PCSrcM",
                         "RegWriteW", "MemToRegW", "PCSrcW", "FlagsQ",
                         "BranchTakenE", "ALUControlE", "ALUSrcE", "MemToRegE",
                         "RegSrcD", "ImmSrcD"};

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
    } exp_t;
    exp_t sb[$];

    function automatic logic [3:0] sample(input int id);
        case (id)
            S_RWM:   return {3'b0, RegWriteM};
            S_MWM:   return {3'b0, MemWriteM};
            S_MRM:   return {3'b0, MemToRegM};
            S_PCM:   return {3'b0, PCSrcM};
            S_RWW:   return {3'b0, RegWriteW};
            S_MRW:   return {3'b0, MemToRegW};
            S_PCW:   return {3'b0, PCSrcW};
            S_FLG:   return FlagsQ;
            S_BTE:   return {3'b0, BranchTakenE};
            S_ALE:   return ALUControlE;
            S_ASE:   return {3'b0, ALUSrcE};
            S_MRE:   return {3'b0, MemToRegE};
            S_RSD:   return {2'b0, RegSrcD};
            S_ISD:   return {2'b0, ImmSrcD};
            default: return 4'hx;
        endcase
    endfunction

    // Scoreboard push: expect signal `id` to equal `v` `off` cycles from now.
    task automatic want(input int off, input int id, input logic [3:0] v);
        exp_t e;
        e.cyc = cyc + off;
        e.sig = id;
        e.val = v;
        sb.push_back(e);
    endtask

    // Monitor: compares every record due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [3:0] act;
                act = sample(sb[i].sig);
                checks++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s @cyc%0d actual=%h required=%h",
                             names[sb[i].sig], cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic [3:0] cond);
        Op = op; Funct = f; Rd = rd; Cond = cond;
    endtask

    task automatic idle();
        issue(2'b11, 6'b000000, 4'h0, 4'b1110);
    endtask

    task automatic ectl(input logic stall, input logic flush, input logic [3:0] flags);
        StallE = stall; FlushE = flush; ALUFlags = flags;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        ectl(1'b0, 1'b0, 4'b0000);

        // Reset state
        nxt();
        want(0, S_FLG, 4'h0); want(0, S_RWM, 0); want(0, S_RWW, 0);
        want(0, S_PCW, 0);    want(0, S_BTE, 0);
        reset = 1'b1;
        nxt();
        nxt();

        // ADD r3 (no S): M two edges later, W three, flags untouched
        issue(2'b00, 6'b001000, 4'd3, 4'b1110);
        want(0, S_RSD, 0); want(0, S_ISD, 0);
        want(1, S_ALE, 4'h4); want(1, S_ASE, 0);
        want(2, S_RWM, 1); want(2, S_MWM, 0); want(2, S_FLG, 4'h0);
        want(3, S_RWW, 1);
        nxt();

        // CMP: flags 0100 loaded after its E edge
        issue(2'b00, 6'b010101, 4'd0, 4'b1110);
        ectl(1'b0, 1'b0, 4'b1111);                 // ADD in E, no flag write
        want(1, S_ALE, 4'h2); want(2, S_RWM, 0); want(2, S_FLG, 4'b0100);
        nxt();

        // BEQ with Z=1: taken
        issue(2'b10, 6'b000000, 4'd0, 4'b0000);
        ectl(1'b0, 1'b0, 4'b0100);                 // CMP in E
        want(0, S_RSD, 4'b01); want(0, S_ISD, 4'b10);
        want(1, S_BTE, 1); want(1, S_ASE, 1); want(1, S_ALE, 4'h4);
        want(2, S_RWM, 0); want(2, S_PCM, 0);
        nxt();

        // BNE with Z=1: not taken
        issue(2'b10, 6'b000000, 4'd0, 4'b0001);
        ectl(1'b0, 1'b0, 4'b1111);                 // BEQ in E
        want(1, S_BTE, 0); want(1, S_FLG, 4'b0100); want(2, S_PCM, 0);
        nxt();

        // BL (Rd=15 must not raise PCSrc for a branch)
        issue(2'b10, 6'b010000, 4'hF, 4'b1110);
        ectl(1'b0, 1'b0, 4'b0000);
        want(1, S_BTE, 1); want(2, S_RWM, 1); want(2, S_PCM, 0);
        want(3, S_RWW, 1); want(3, S_PCW, 0);
        nxt();

        // ANDS: only N,Z written -> 0100 becomes 1000 with ALUFlags 1011
        issue(2'b00, 6'b000001, 4'd1, 4'b1110);
        ectl(1'b0, 1'b0, 4'b0000);
        want(1, S_ALE, 4'h0); want(2, S_RWM, 1); want(2, S_FLG, 4'b1000);
        nxt();

        // ADDEQ with Z=0: suppressed
        issue(2'b00, 6'b001000, 4'd4, 4'b0000);
        ectl(1'b0, 1'b0, 4'b1011);                 // ANDS in E
        want(2, S_RWM, 0);
        nxt();

        // MOVLT pc, #imm with N=1,V=0: executes and redirects PC
        issue(2'b00, 6'b111010, 4'hF, 4'b1011);
        ectl(1'b0, 1'b0, 4'b0000);
        want(1, S_ASE, 1); want(1, S_ALE, 4'hD);
        want(2, S_RWM, 1); want(2, S_PCM, 1); want(3, S_PCW, 1);
        nxt();

        // STR, register offset, subtract
        issue(2'b01, 6'b100000, 4'd5, 4'b1110);
        want(0, S_RSD, 4'b10); want(0, S_ISD, 4'b01);
        want(1, S_ASE, 0); want(1, S_ALE, 4'h2);
        want(2, S_MWM, 1); want(2, S_RWM, 0); want(2, S_MRM, 0);
        nxt();

        // LDR stalled one cycle in E
        issue(2'b01, 6'b011001, 4'd2, 4'b1110);
        want(1, S_MRE, 1); want(1, S_ASE, 1); want(1, S_ALE, 4'h4);
        want(2, S_RWM, 0); want(2, S_MRM, 0); want(2, S_MRE, 1);
        want(3, S_RWM, 1); want(3, S_MRM, 1);
        want(4, S_RWW, 1); want(4, S_MRW, 1);
        nxt();
        idle();
        ectl(1'b1, 1'b0, 4'b0000);
        want(0, S_RSD, 0); want(0, S_ISD, 0);
        nxt();
        ectl(1'b0, 1'b0, 4'b0000);
        nxt();

        // ADDS stalled: flags untouched during stall, written after
        issue(2'b00, 6'b001001, 4'd6, 4'b1110);
        want(2, S_FLG, 4'b1000); want(2, S_RWM, 0);
        want(3, S_FLG, 4'b0110); want(3, S_RWM, 1);
        nxt();
        idle();
        ectl(1'b1, 1'b0, 4'b0011);
        nxt();
        ectl(1'b0, 1'b0, 4'b0110);
        nxt();

        // ADDS flushed and stalled in the same cycle: killed outright
        issue(2'b00, 6'b001001, 4'd7, 4'b1110);
        ectl(1'b0, 1'b0, 4'b0000);
        want(2, S_FLG, 4'b0110); want(2, S_RWM, 0); want(2, S_ALE, 4'h0);
        want(3, S_FLG, 4'b0110); want(3, S_RWW, 0);
        nxt();
        idle();
        ectl(1'b1, 1'b1, 4'b1111);
        nxt();
        ectl(1'b0, 1'b0, 4'b0001);
        nxt();

        // Asynchronous reset mid-stream
        issue(2'b00, 6'b001000, 4'd3, 4'b1110);
        ectl(1'b0, 1'b0, 4'b0000);
        want(2, S_RWM, 1);
        nxt();
        issue(2'b00, 6'b001000, 4'd8, 4'b1110);
        nxt();
        idle();
        nxt();
        want(0, S_RWM, 0); want(0, S_RWW, 0); want(0, S_FLG, 4'h0);
        want(0, S_PCM, 0); want(0, S_MRW, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (RegWriteM !== 1'b0) begin
            failures++;
            $display("FAIL RegWriteM async reset actual=%b required=0", RegWriteM);
        end
        checks++;
        if (RegWriteW !== 1'b0) begin
            failures++;
            $display("FAIL RegWriteW async reset actual=%b required=0", RegWriteW);
        end
        checks++;
        if (FlagsQ !== 4'h0) begin
            failures++;
            $display("FAIL FlagsQ async reset actual=%h required=0", FlagsQ);
        end
        checks++;
        if (PCSrcM !== 1'b0) begin
            failures++;
            $display("FAIL PCSrcM async reset actual=%b required=0", PCSrcM);
        end
        checks++;
        if (MemWriteM !== 1'b0) begin
            failures++;
            $display("FAIL MemWriteM async reset actual=%b required=0", MemWriteM);
        end
        checks++;
        if (MemToRegW !== 1'b0) begin
            failures++;
            $display("FAIL MemToRegW async reset actual=%b required=0", MemToRegW);
        end
        nxt();
        want(0, S_FLG, 4'h0); want(0, S_RWW, 0);
        reset = 1'b1;
        repeat (3) nxt();

        // Anything still queued was never compared.
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s never compared (due cyc%0d) required=%h",
                     names[sb[i].sig], sb[i].cyc, sb[i].val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
